// File: rtl/ecc_bank_pkg.sv
// Shared types and helpers for the ECC cache bank and its per-way storage.
package ecc_bank_pkg;

  typedef enum logic {
    Init,
    Ready
  } bank_state_e;

  function automatic int line_width(input int numBlocks, input int blockWidth);
    return numBlocks * blockWidth;
  endfunction

  // Range test done at 32 bits so a power-of-two bound never folds to a constant.
  function automatic logic in_range(input logic [31:0] value, input logic [31:0] limit);
    return value < limit;
  endfunction

endpackage

// File: rtl/ecc_bank_way.sv
// One way of the bank: raw codeword array with per-block writes, held registered
// read port, single-bit flip port and a synchronous clear used during Init.
module ecc_bank_way
  import ecc_bank_pkg::*;
#(
  parameter int BankSize      = 256,
  parameter int BlockWidthECC = 39,
  parameter int NumBlocks     = 2,
  parameter int LineWidth     = line_width(NumBlocks, BlockWidthECC),
  parameter int AddrWidth     = $clog2(BankSize),
  parameter int BitWidth      = $clog2(LineWidth)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic [AddrWidth-1:0] clr_add_i,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] add_i,
  input  logic [NumBlocks-1:0] be_i,
  input  logic [LineWidth-1:0] wdata_i,
  input  logic                 flip_i,
  input  logic [AddrWidth-1:0] flip_add_i,
  input  logic [BitWidth-1:0]  flip_bit_i,
  output logic [LineWidth-1:0] rdata_o,
  output logic                 rvalid_o
);

  logic [LineWidth-1:0] r_mem [BankSize];
  logic [LineWidth-1:0] r_rdata;
  logic                 r_rvalid;

  logic                 w_addOk;
  logic                 w_flipAddOk;
  logic [LineWidth-1:0] w_beMask;
  logic [LineWidth-1:0] w_flipMask;

  assign w_addOk     = in_range(32'(add_i), 32'(BankSize));
  assign w_flipAddOk = in_range(32'(flip_add_i), 32'(BankSize));

  // A bit index past the line shifts the one out entirely, making the flip a no-op.
  assign w_flipMask  = LineWidth'(1) << flip_bit_i;

  always_comb begin
    w_beMask = '0;
    for (int j = 0; j < NumBlocks; j++) begin
      w_beMask[j*BlockWidthECC +: BlockWidthECC] = {BlockWidthECC{be_i[j]}};
    end
  end

  // Storage is deliberately not reset; the top sweeps clr_i across it after reset.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      r_mem[clr_add_i] <= '0;
    end else if (req_i && we_i && w_addOk) begin
      r_mem[add_i] <= (r_mem[add_i] & ~w_beMask) | (wdata_i & w_beMask);
    end else if (flip_i && w_flipAddOk) begin
      r_mem[flip_add_i] <= r_mem[flip_add_i] ^ w_flipMask;
    end
  end

  // Read data is held until the next read of this way.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= 1'b0;
      if (req_i && !we_i) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_addOk ? r_mem[add_i] : '0;
      end
    end
  end

  assign rdata_o  = r_rdata;
  assign rvalid_o = r_rvalid;

endmodule

// File: rtl/ecc_cache_bank.sv
// Multi-way ECC-word-granular cache bank responder: self-initialises to zero lines,
// serves per-way reads/writes, and offers a low-priority single-bit fault injector.
module ecc_cache_bank
  import ecc_bank_pkg::*;
#(
  parameter  int Assoc         = 2,
  parameter  int BankSize      = 256,
  parameter  int BlockWidthECC = 39,
  parameter  int NumBlocks     = 2,
  localparam int LineWidth     = line_width(NumBlocks, BlockWidthECC),
  localparam int AddrWidth     = $clog2(BankSize),
  localparam int WayWidth      = (Assoc > 1) ? $clog2(Assoc) : 1,
  localparam int BitWidth      = $clog2(LineWidth)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [Assoc-1:0]           req_i,
  input  logic                       we_i,
  input  logic [AddrWidth-1:0]       add_i,
  input  logic [NumBlocks-1:0]       be_i,
  input  logic [LineWidth-1:0]       wdata_i,
  output logic [Assoc*LineWidth-1:0] rdata_o,
  output logic [Assoc-1:0]           rvalid_o,
  output logic                       ready_o,
  input  logic                       inject_req_i,
  input  logic [WayWidth-1:0]        inject_way_i,
  input  logic [AddrWidth-1:0]       inject_add_i,
  input  logic [BitWidth-1:0]        inject_bit_i,
  output logic                       inject_gnt_o,
  output logic [15:0]                inject_cnt_o
);

  bank_state_e          r_state;
  bank_state_e          w_stateNext;
  logic [AddrWidth-1:0] r_initCnt;
  logic [15:0]          r_injCnt;

  logic                 w_clr;
  logic                 w_ready;
  logic                 w_injGnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= Init;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Bank traffic always wins: injection is only granted on a cycle with no request.
  always_comb begin
    w_stateNext = r_state;
    w_clr       = 1'b0;
    w_ready     = 1'b0;
    w_injGnt    = 1'b0;
    case (r_state)
      Init: begin
        w_clr = 1'b1;
        if (r_initCnt == AddrWidth'(BankSize - 1)) begin
          w_stateNext = Ready;
        end
      end
      Ready: begin
        w_ready  = 1'b1;
        w_injGnt = inject_req_i && (req_i == '0);
      end
      default: w_stateNext = Init;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_initCnt <= '0;
    end else if (r_state == Init) begin
      r_initCnt <= r_initCnt + AddrWidth'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_injCnt <= '0;
    end else if (w_injGnt && (r_injCnt != 16'hFFFF)) begin
      r_injCnt <= r_injCnt + 16'd1;
    end
  end

  for (genvar w = 0; w < Assoc; w++) begin : g_way
    logic w_flip;
    assign w_flip = w_injGnt && (inject_way_i == WayWidth'(w));

    ecc_bank_way #(
      .BankSize      (BankSize),
      .BlockWidthECC (BlockWidthECC),
      .NumBlocks     (NumBlocks),
      .LineWidth     (LineWidth),
      .AddrWidth     (AddrWidth),
      .BitWidth      (BitWidth)
    ) u_way (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .clr_i      (w_clr),
      .clr_add_i  (r_initCnt),
      .req_i      (w_ready && req_i[w]),
      .we_i       (we_i),
      .add_i      (add_i),
      .be_i       (be_i),
      .wdata_i    (wdata_i),
      .flip_i     (w_flip),
      .flip_add_i (inject_add_i),
      .flip_bit_i (inject_bit_i),
      .rdata_o    (rdata_o[w*LineWidth +: LineWidth]),
      .rvalid_o   (rvalid_o[w])
    );
  end

  assign ready_o      = w_ready;
  assign inject_gnt_o = w_injGnt;
  assign inject_cnt_o = r_injCnt;

endmodule

// File: tb/tb_ecc_cache_bank.sv
// Directed, scoreboard-based bench for ecc_cache_bank with a small reference model
// of both ways, the held read registers and the injection counter.
module tb_ecc_cache_bank;

  localparam int Assoc    = 2;
  localparam int BankSize = 256;
  localparam int BlkW     = 39;
  localparam int LineW    = 78;

  typedef struct {
    logic [1:0]         valid;
    logic [2*LineW-1:0] rdata;
    logic [15:0]        cnt;
  } exp_t;

  logic               clk_i = 1'b0;
  logic               rst_ni;
  logic [1:0]         req_i;
  logic               we_i;
  logic [7:0]         add_i;
  logic [1:0]         be_i;
  logic [LineW-1:0]   wdata_i;
  logic [2*LineW-1:0] rdata_o;
  logic [1:0]         rvalid_o;
  logic               ready_o;
  logic               inject_req_i;
  logic [0:0]         inject_way_i;
  logic [7:0]         inject_add_i;
  logic [6:0]         inject_bit_i;
  logic               inject_gnt_o;
  logic [15:0]        inject_cnt_o;

  logic [LineW-1:0] model [Assoc][BankSize];
  logic [LineW-1:0] lastRd [Assoc];
  logic [15:0]      expCnt;
  exp_t             sbQ [$];
  int               nChecks = 0;
  int               nPass   = 0;
  int               nFail   = 0;

  ecc_cache_bank dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_i        (req_i),
    .we_i         (we_i),
    .add_i        (add_i),
    .be_i         (be_i),
    .wdata_i      (wdata_i),
    .rdata_o      (rdata_o),
    .rvalid_o     (rvalid_o),
    .ready_o      (ready_o),
    .inject_req_i (inject_req_i),
    .inject_way_i (inject_way_i),
    .inject_add_i (inject_add_i),
    .inject_bit_i (inject_bit_i),
    .inject_gnt_o (inject_gnt_o),
    .inject_cnt_o (inject_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    nChecks++;
    assert (obs === expv) nPass++;
    else begin
      nFail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic resetModel();
    for (int w = 0; w < Assoc; w++) begin
      lastRd[w] = '0;
      for (int a = 0; a < BankSize; a++) model[w][a] = '0;
    end
    expCnt = '0;
  endtask

  task automatic driveIdle();
    req_i        = '0;
    we_i         = 1'b0;
    add_i        = '0;
    be_i         = '0;
    wdata_i      = '0;
    inject_req_i = 1'b0;
    inject_way_i = '0;
    inject_add_i = '0;
    inject_bit_i = '0;
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sbQ.size() == 0) begin
      check("scoreboard_empty", 256'(1), 256'(0));
      return;
    end
    e = sbQ.pop_front();
    check("rvalid", 256'(rvalid_o), 256'(e.valid));
    check("rdata", 256'(rdata_o), 256'(e.rdata));
    check("inject_cnt", 256'(inject_cnt_o), 256'(e.cnt));
  endtask

  // One Ready-state cycle: drive, check the combinational grant, update the model,
  // queue the expectation, then compare after the clock edge.
  task automatic applyStimulus(input logic [1:0] req, input logic we, input logic [7:0] add,
                               input logic [1:0] be, input logic [LineW-1:0] wdata,
                               input logic injReq, input logic injWay,
                               input logic [7:0] injAdd, input logic [6:0] injBit);
    exp_t e;
    logic expGnt;
    req_i = req; we_i = we; add_i = add; be_i = be; wdata_i = wdata;
    inject_req_i = injReq; inject_way_i = injWay;
    inject_add_i = injAdd; inject_bit_i = injBit;
    #1;
    expGnt = injReq && (req == 2'b00);
    check("inject_gnt", 256'(inject_gnt_o), 256'(expGnt));
    if (expGnt) begin
      if (expCnt != 16'hFFFF) expCnt = expCnt + 16'd1;
      if (injBit < LineW) model[injWay][injAdd][injBit] = ~model[injWay][injAdd][injBit];
    end
    e.valid = 2'b00;
    for (int w = 0; w < Assoc; w++) begin
      if (req[w] && we) begin
        for (int j = 0; j < 2; j++) begin
          if (be[j]) model[w][add][j*BlkW +: BlkW] = wdata[j*BlkW +: BlkW];
        end
      end else if (req[w]) begin
        lastRd[w]  = model[w][add];
        e.valid[w] = 1'b1;
      end
    end
    e.rdata = {lastRd[1], lastRd[0]};
    e.cnt   = expCnt;
    sbQ.push_back(e);
    @(posedge clk_i); #1;
    checkOutput();
  endtask

  task automatic idle();
    applyStimulus(2'b00, 1'b0, 8'd0, 2'b00, '0, 1'b0, 1'b0, 8'd0, 7'd0);
  endtask

  task automatic waitReady(output int cycles);
    cycles = 0;
    while (!ready_o && cycles < 1000) begin
      @(posedge clk_i); #1;
      cycles++;
    end
  endtask

  initial begin
    int cycles;
    logic [95:0] rnd;
    logic [LineW-1:0] flipped;

    driveIdle();
    resetModel();
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_ready", 256'(ready_o), 256'(0));
    check("reset_rvalid", 256'(rvalid_o), 256'(0));
    check("reset_rdata", 256'(rdata_o), 256'(0));
    check("reset_gnt", 256'(inject_gnt_o), 256'(0));
    check("reset_cnt", 256'(inject_cnt_o), 256'(0));

    // Injection during Init must be ignored.
    rst_ni = 1'b1;
    inject_req_i = 1'b1;
    repeat (10) @(posedge clk_i);
    #1;
    check("init_gnt", 256'(inject_gnt_o), 256'(0));
    check("init_ready", 256'(ready_o), 256'(0));
    inject_req_i = 1'b0;
    waitReady(cycles);
    check("init_cycles", 256'(cycles + 10), 256'(BankSize));
    check("init_cnt", 256'(inject_cnt_o), 256'(0));

    applyStimulus(2'b10, 1'b0, 8'hFF, 2'b00, '0, 1'b0, 1'b0, 8'd0, 7'd0);

    // Upper block only, way0 only.
    applyStimulus(2'b01, 1'b1, 8'd5, 2'b10, {LineW{1'b1}}, 1'b0, 1'b0, 8'd0, 7'd0);
    applyStimulus(2'b11, 1'b0, 8'd5, 2'b00, '0, 1'b0, 1'b0, 8'd0, 7'd0);
    check("partial_way0", 256'(rdata_o[LineW-1:0]), 256'({39'h7FFFFFFFFF, 39'h0}));
    check("partial_way1", 256'(rdata_o[2*LineW-1:LineW]), 256'(0));

    applyStimulus(2'b01, 1'b0, 8'd5, 2'b00, '0, 1'b0, 1'b0, 8'd0, 7'd0);
    repeat (3) idle();

    rnd = {$urandom(), $urandom(), $urandom()};
    applyStimulus(2'b10, 1'b1, 8'd7, 2'b11, rnd[LineW-1:0], 1'b0, 1'b0, 8'd0, 7'd0);
    applyStimulus(2'b10, 1'b0, 8'd7, 2'b01, '0, 1'b0, 1'b0, 8'd0, 7'd0);
    applyStimulus(2'b01, 1'b1, 8'd7, 2'b01, ~rnd[LineW-1:0], 1'b0, 1'b0, 8'd0, 7'd0);
    applyStimulus(2'b11, 1'b0, 8'd7, 2'b00, '0, 1'b0, 1'b0, 8'd0, 7'd0);

    // Injection is held off while traffic is present, then granted when it stops.
    repeat (4) applyStimulus(2'b11, 1'b0, 8'd5, 2'b00, '0, 1'b1, 1'b0, 8'd5, 7'd3);
    applyStimulus(2'b00, 1'b0, 8'd0, 2'b00, '0, 1'b1, 1'b0, 8'd5, 7'd3);
    applyStimulus(2'b01, 1'b0, 8'd5, 2'b00, '0, 1'b0, 1'b0, 8'd0, 7'd0);
    flipped = {39'h7FFFFFFFFF, 39'h0};
    flipped[3] = 1'b1;
    check("inject_flip", 256'(rdata_o[LineW-1:0]), 256'(flipped));

    applyStimulus(2'b00, 1'b0, 8'd0, 2'b00, '0, 1'b1, 1'b1, 8'd7, 7'd100);
    applyStimulus(2'b10, 1'b0, 8'd7, 2'b00, '0, 1'b0, 1'b0, 8'd0, 7'd0);
    check("inject_oor_mem", 256'(rdata_o[2*LineW-1:LineW]), 256'(rnd[LineW-1:0]));
    check("inject_oor_cnt", 256'(inject_cnt_o), 256'(2));

    applyStimulus(2'b00, 1'b0, 8'd0, 2'b00, '0, 1'b1, 1'b1, 8'd200, 7'd77);
    applyStimulus(2'b10, 1'b0, 8'd200, 2'b00, '0, 1'b0, 1'b0, 8'd0, 7'd0);

    // Reset while Init is at line 100 must restart the full sweep.
    driveIdle();
    rst_ni = 1'b0;
    #2;
    check("rst_ready", 256'(ready_o), 256'(0));
    rst_ni = 1'b1;
    repeat (100) @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    #2;
    check("midinit_cnt", 256'(inject_cnt_o), 256'(0));
    check("midinit_rdata", 256'(rdata_o), 256'(0));
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    resetModel();
    waitReady(cycles);
    check("midinit_cycles", 256'(cycles), 256'(BankSize));
    applyStimulus(2'b11, 1'b0, 8'd5, 2'b00, '0, 1'b0, 1'b0, 8'd0, 7'd0);
    applyStimulus(2'b10, 1'b0, 8'd200, 2'b00, '0, 1'b0, 1'b0, 8'd0, 7'd0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
